data_bus: RTL and testbench

Data-side bus stage directly downstream of the single-cycle RV32I core. It consumes the core's `address`, `WE` and `writeData` and returns `readData` in the same cycle. It decodes the 16-bit byte address into a word RAM and a memory-mapped UART transmitter with a transmit FIFO. The UART serialises queued bytes as 8N1 frames on `uart_tx`.

---
 rtl/data_bus.sv | 193 +++++++++++++++++++
 tb/tb_data_bus.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus.sv
// Data-side bus stage: word RAM plus a memory-mapped 8N1 UART transmitter with a TX FIFO.
// Optional feature macro: DATA_BUS_CYCLE_COUNTER_EN adds a 32-bit cycle counter at 0x8008.
module data_bus #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CLK_DIV    = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic        WE,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        uart_tx
);

  localparam int unsigned RamAw = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned DivW  = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [4:0]      DepthC  = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  // Address decode; bits [1:0] are ignored everywhere.
  logic [13:0]      word_addr;
  logic             sel_ram, sel_data, sel_stat, sel_cyc;
  logic [RamAw-1:0] ram_idx;

  assign word_addr = address[15:2];
  assign sel_ram   = ~address[15];
  assign sel_data  = (word_addr == 14'h2000);
  assign sel_stat  = (word_addr == 14'h2001);
  assign sel_cyc   = (word_addr == 14'h2002);
  assign ram_idx   = address[RamAw+1:2];

  logic [31:0]     ram_mem [RAM_WORDS];
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  tx_state_e       state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic full, empty, push_req, push_ok, pop, div_last;

  assign full     = (count_q == DepthC);
  assign empty    = (count_q == 5'd0);
  assign push_req = WE & sel_data;
  // Acceptance uses the pre-edge count, so a full FIFO drops the push even if it pops this edge.
  assign push_ok  = push_req & ~full;
  assign div_last = (div_q == DivLast);

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (WE && sel_ram) ram_mem[ram_idx] <= writeData;
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= writeData[7:0];
  end

  // FIFO occupancy and sticky overflow next-state.
  always_comb begin
    count_d = count_q + {4'd0, push_ok} - {4'd0, pop};
    ovf_d   = ovf_q;
    if (WE && sel_stat)         ovf_d = 1'b0;
    else if (push_req && full)  ovf_d = 1'b1;
  end

  // Transmitter next-state: pops the head byte when leaving IDLE or finishing a stop bit.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StStart;
          shift_d = fifo_mem[rd_ptr_q];
          div_d   = '0;
        end
      end
      StStart: begin
        if (div_last) begin
          state_d = StData;
          div_d   = '0;
          bit_d   = 3'd0;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StData: begin
        if (div_last) begin
          div_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StStop: begin
        if (div_last) begin
          div_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = StStart;
            shift_d = fifo_mem[rd_ptr_q];
          end else begin
            state_d = StIdle;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
    endcase
    // Line level is registered from the next state so uart_tx never glitches.
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      StIdle,
      StStop:  tx_d = 1'b1;
    endcase
  end

  // Transmitter and FIFO control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  assign uart_tx = tx_q;

  logic [31:0] status;
  assign status = {23'd0, count_q, ovf_q, empty, full, (state_q != StIdle)};

`ifdef DATA_BUS_CYCLE_COUNTER_EN
  logic [31:0] cyc_q;

  // Free-running cycle counter; a write restarts it from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cyc_q <= 32'd0;
    else if (WE && sel_cyc) cyc_q <= 32'd0;
    else                   cyc_q <= cyc_q + 32'd1;
  end

  logic unused_addr;
  assign unused_addr = ^address;
`else
  logic [31:0] cyc_q;
  assign cyc_q = 32'd0;

  logic unused_addr;
  assign unused_addr = ^{address, sel_cyc};
`endif

  // Combinational read mux.
  always_comb begin
    readData = 32'd0;
    if (sel_ram)       readData = ram_mem[ram_idx];
    else if (sel_stat) readData = status;
    else if (sel_cyc)  readData = cyc_q;
  end

endmodule

// File: tb/tb_data_bus.sv
// Randomised self-checking bench for data_bus with a transaction-level model.
module tb_data_bus;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int RW    = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] address = 16'd0;
  logic        WE = 1'b0;
  logic [31:0] writeData = 32'd0;
  logic [31:0] readData;
  logic        uart_tx;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_bus #(
    .RAM_WORDS (RW),
    .FIFO_DEPTH(DEPTH),
    .CLK_DIV   (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .WE       (WE),
    .writeData(writeData),
    .readData (readData),
    .uart_tx  (uart_tx)
  );

  // Model state: RAM image, byte queue, frame-in-flight as remaining cycles.
  logic [31:0] ram_m [RW];
  bit          ram_v [RW];
  logic [7:0]  q_m [$];
  bit          ovf_m = 1'b0;
  int          rem_m = 0;
  logic [9:0]  frame_m = 10'h3ff;
  logic [31:0] cyc_m = 32'd0;
  int          m_pre;
  logic [7:0]  m_byte;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_m.delete();
      ovf_m = 1'b0;
      rem_m = 0;
      cyc_m = 32'd0;
    end else begin
      m_pre = q_m.size();
      if (rem_m > 1) begin
        rem_m = rem_m - 1;
      end else if (m_pre > 0) begin
        m_byte  = q_m.pop_front();
        frame_m = {1'b1, m_byte, 1'b0};
        rem_m   = 10 * D;
      end else begin
        rem_m = 0;
      end
      if (WE) begin
        if (address < 16'h8000) begin
          ram_m[(address >> 2) % RW] = writeData;
          ram_v[(address >> 2) % RW] = 1'b1;
        end else if ((address >> 2) == 16'h2000) begin
          if (m_pre < DEPTH) q_m.push_back(writeData[7:0]);
          else               ovf_m = 1'b1;
        end else if ((address >> 2) == 16'h2001) begin
          ovf_m = 1'b0;
        end
      end
`ifdef DATA_BUS_CYCLE_COUNTER_EN
      if (WE && (address >> 2) == 16'h2002) cyc_m = 32'd0;
      else                                  cyc_m = cyc_m + 32'd1;
`endif
    end
  end

  function automatic logic exp_tx();
    if (rem_m == 0) return 1'b1;
    return frame_m[(10 * D - rem_m) / D];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [15:0] a, output bit known);
    logic [31:0] s;
    int n;
    known = 1'b1;
    s = 32'd0;
    if (a < 16'h8000) begin
      known = ram_v[(a >> 2) % RW];
      return ram_m[(a >> 2) % RW];
    end
    if ((a >> 2) == 16'h2001) begin
      n = q_m.size();
      s[0]   = (rem_m != 0);
      s[1]   = (n == DEPTH);
      s[2]   = (n == 0);
      s[3]   = ovf_m;
      s[8:4] = 5'(n);
    end else if ((a >> 2) == 16'h2002) begin
      s = cyc_m;
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] e;
    bit k;
    check("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx()});
    e = exp_rd(address, k);
    if (k) check("readData", readData, e);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    address   = a;
    writeData = d;
    WE        = 1'b1;
    cyc();
    WE        = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [31:0] e);
    address = a;
    WE      = 1'b0;
    #2;
    check(name, readData, e);
    cyc();
  endtask

  int exp_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int n;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    address = 16'h8004;
    #1;
    check("reset_status", readData, 32'h4);
    check("reset_tx", {31'd0, uart_tx}, 32'd1);
    rst = 1'b0;
    cyc();

    // RAM round trip, low-bit ignore and depth aliasing.
    wr(16'h0010, 32'hDEADBEEF);
    wr(16'h0014, 32'h12345678);
    rd_check("ram_0010", 16'h0010, 32'hDEADBEEF);
    rd_check("ram_0013", 16'h0013, 32'hDEADBEEF);
    rd_check("ram_0014", 16'h0014, 32'h12345678);
    rd_check("ram_alias", 16'h0410, 32'hDEADBEEF);

    // Single 0xA5 frame sampled at bit centres.
    wr(16'h8000, 32'h000000A5);
    address = 16'h8004;
    cyc();
    cyc();
    cyc();
    for (int b = 0; b < 10; b++) begin
      check($sformatf("frame_bit%0d", b), {31'd0, uart_tx}, 32'(exp_bits[b]));
      check($sformatf("frame_busy%0d", b), {31'd0, readData[0]}, 32'd1);
      if (b < 9) repeat (4) cyc();
    end
    repeat (2) cyc();
    check("frame_done_status", readData, 32'h4);

    // FIFO fill and overflow, then back-to-back drain.
    for (int i = 0; i < 6; i++) wr(16'h8000, 32'h30 + 32'(i));
    address = 16'h8004;
    #1;
    check("ovf_status", readData, 32'h4B);
    wr(16'h8004, 32'd0);
    #1;
    check("ovf_cleared", readData, 32'h43);
    n = 0;
    while (readData[0] && n < 400) begin
      cyc();
      n++;
    end
    check("drain_cycles", 32'(n), 32'd195);
    check("drain_status", readData, 32'h4);

    // Reset in the middle of data bit 3 with a byte still queued.
    wr(16'h0020, 32'hCAFEF00D);
    wr(16'h8000, 32'h00);
    wr(16'h8000, 32'h55);
    repeat (17) cyc();
    #1;
    check("tx_low_before_rst", {31'd0, uart_tx}, 32'd0);
    rst = 1'b1;
    #1;
    check("tx_async_rst", {31'd0, uart_tx}, 32'd1);
    cyc();
    cyc();
    rst = 1'b0;
    address = 16'h8004;
    #1;
    check("rst_status", readData, 32'h4);
    repeat (3) cyc();
    check("rst_discard", readData, 32'h4);
    rd_check("rst_ram_kept", 16'h0020, 32'hCAFEF00D);

    // Unmapped access.
    wr(16'h9000, 32'hFFFFFFFF);
    rd_check("unmapped_rd", 16'h9000, 32'd0);
    rd_check("unmapped_ram", 16'h0020, 32'hCAFEF00D);
    rd_check("unmapped_stat", 16'h8004, 32'h4);

`ifdef DATA_BUS_CYCLE_COUNTER_EN
    wr(16'h8008, 32'd123);
    repeat (10) cyc();
    address = 16'h8008;
    #1;
    check("cycle_10", readData, 32'd10);
`else
    rd_check("cycle_absent", 16'h8008, 32'd0);
`endif

    // Randomised traffic across all regions.
    for (int i = 0; i < 1500; i++) begin
      int c;
      c = $urandom_range(0, 9);
      case (c)
        0, 1, 2: address = 16'($urandom_range(0, 255));
        3:       address = 16'($urandom_range(0, 16'h7FFF));
        4, 5:    address = 16'h8000;
        6:       address = 16'h8004;
        7:       address = 16'h8008;
        8:       address = 16'h9000 | 16'($urandom_range(0, 16'h0FFF));
        default: address = 16'($urandom_range(0, 16'hFFFF));
      endcase
      WE        = 1'($urandom_range(0, 1));
      writeData = $urandom;
      cyc();
    end
    WE = 1'b0;
    address = 16'h8004;
    repeat (250) cyc();
    check("final_idle", readData & 32'h1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
